vga_sprite_scene: RTL and testbench

VGA_SPRITE_SCENE -- requirements
Module: vga_sprite_scene

---
 rtl/vga_sprite_scene.sv | 176 +++++++++++++++++
 tb/tb_vga_sprite_scene.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_scene.sv
// VGA 640x480 timing generator with N keyboard-steered bouncing square balls.
// Pixel outputs are registered one pixel behind DrawX/DrawY.
module vga_sprite_scene #(
  parameter int N_BALLS   = 2,
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1,
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       hs,
  output logic       vs,
  output logic       VGA_clk,
  output logic       blank,
  output logic       sync,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG     = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG     = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
  localparam logic [9:0] H_EDGE     = 10'(H_VIS - 1);
  localparam logic [9:0] V_EDGE     = 10'(V_VIS - 1);
  localparam logic [9:0] BS         = 10'(BALL_SIZE);
  localparam logic signed [10:0] BS_S     = 11'(BALL_SIZE);
  localparam logic signed [9:0]  STEP_POS = 10'(STEP);
  localparam logic signed [9:0]  STEP_NEG = -STEP_POS;
  localparam logic [7:0] KEY_SEL_LAST = 8'(8'h1E + N_BALLS - 1);

  logic       pe;
  logic [9:0] hc, vc;
  logic       hs_raw, vs_raw, blank_raw;
  logic [23:0] rgb_raw;
  logic [1:0] sel;

  logic [9:0]        ball_x  [N_BALLS];
  logic [9:0]        ball_y  [N_BALLS];
  logic signed [9:0] ball_xm [N_BALLS];
  logic signed [9:0] ball_ym [N_BALLS];
  logic signed [9:0] nxt_xm  [N_BALLS];
  logic signed [9:0] nxt_ym  [N_BALLS];

  logic              hit;
  logic [1:0]        hit_idx;
  logic signed [10:0] dx, dy, adx, ady;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pe <= 1'b0;
      hc <= '0;
      vc <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  assign VGA_clk     = pe;
  assign sync        = 1'b0;
  assign DrawX       = hc;
  assign DrawY       = vc;
  assign hs_raw      = !(hc >= HS_BEG && hc < HS_END);
  assign vs_raw      = !(vc >= VS_BEG && vc < VS_END);
  assign blank_raw   = (hc < H_VIS_W) && (vc < V_VIS_W);
  assign frame_start = pe && (hc == H_LAST) && (vc == V_EDGE);

  // Keys steer only the selected ball; a wall contact then overrides its own axis.
  always_comb begin
    for (int i = 0; i < N_BALLS; i++) begin
      // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
      nxt_xm[i] = ball_xm[i];
      nxt_ym[i] = ball_ym[i];
      if (sel == 2'(i)) begin
        case (keycode)
          8'h1A: begin nxt_ym[i] = STEP_NEG; nxt_xm[i] = '0; end
          8'h16: begin nxt_ym[i] = STEP_POS; nxt_xm[i] = '0; end
          8'h04: begin nxt_xm[i] = STEP_NEG; nxt_ym[i] = '0; end
          8'h07: begin nxt_xm[i] = STEP_POS; nxt_ym[i] = '0; end
          default: ;
        endcase
      end
      if (ball_y[i] + BS >= V_EDGE)      nxt_ym[i] = STEP_NEG;
      else if (ball_y[i] <= BS)          nxt_ym[i] = STEP_POS;
      if (ball_x[i] + BS >= H_EDGE)      nxt_xm[i] = STEP_NEG;
      else if (ball_x[i] <= BS)          nxt_xm[i] = STEP_POS;
    end
  end

  // NOTE: the ball registers are a handful of flops, so they are reset explicitly like any other state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sel <= '0;
      for (int i = 0; i < N_BALLS; i++) begin
        ball_x[i]  <= 10'((H_VIS / (N_BALLS + 1)) * (i + 1));
        ball_y[i]  <= 10'(V_VIS / 2);
        ball_xm[i] <= '0;
        ball_ym[i] <= '0;
      end
    end else if (frame_start) begin
      // 0x1E..0x21 map to 0..3 through the low two bits alone.
      if (keycode >= 8'h1E && keycode <= KEY_SEL_LAST)
        sel <= keycode[1:0] - 2'b10;
      for (int i = 0; i < N_BALLS; i++) begin
        ball_xm[i] <= nxt_xm[i];
        ball_ym[i] <= nxt_ym[i];
        ball_x[i]  <= ball_x[i] + $unsigned(nxt_xm[i]);
        ball_y[i]  <= ball_y[i] + $unsigned(nxt_ym[i]);
      end
    end
  end

  // Descending scan so the lowest-index covering ball is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    dx = '0; dy = '0; adx = '0; ady = '0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      dx  = $signed({1'b0, hc}) - $signed({1'b0, ball_x[i]});
      dy  = $signed({1'b0, vc}) - $signed({1'b0, ball_y[i]});
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      if (adx <= BS_S && ady <= BS_S) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  always_comb begin
    rgb_raw = 24'h000040;
    if (!blank_raw)           rgb_raw = 24'h000000;
    else if (hit && hit_idx == sel) rgb_raw = 24'hFFFFFF;
    else if (hit)             rgb_raw = 24'hFF5500;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      blank <= 1'b0;
      {Red, Green, Blue} <= '0;
    end else if (pe) begin
      hs    <= hs_raw;
      vs    <= vs_raw;
      blank <= blank_raw;
      {Red, Green, Blue} <= rgb_raw;
    end
  end

endmodule

// File: tb/tb_vga_sprite_scene.sv
// Directed bench for vga_sprite_scene on a reduced raster so whole frames fit a short run.
// Expected values are queued when stimulus is applied and popped at each comparison.
module tb_vga_sprite_scene;

  localparam int N_BALLS = 2, BALL_SIZE = 2, STEP = 1;
  localparam int H_VIS = 24, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 16, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLK = 2 * H_TOT * V_TOT;
  localparam int X0_INIT = (H_VIS / (N_BALLS + 1)) * 1;
  localparam int X1_INIT = (H_VIS / (N_BALLS + 1)) * 2;
  localparam int Y_INIT  = V_VIS / 2;
  localparam int X0_EDGE = H_VIS - 1 - BALL_SIZE;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       hs, vs, VGA_clk, blank, sync, frame_start;
  logic [7:0] Red, Green, Blue;
  logic [9:0] DrawX, DrawY;

  vga_sprite_scene #(
    .N_BALLS(N_BALLS), .BALL_SIZE(BALL_SIZE), .STEP(STEP),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode),
    .hs(hs), .vs(vs), .VGA_clk(VGA_clk), .blank(blank), .sync(sync),
    .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start)
  );

  always #10 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int ex_x0, ex_x1, ex_y0, ex_y1;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
      return;
    end
    expv = exp_q.pop_front();
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_frame_start(input int budget, output int unsigned at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge Clk);
      if (frame_start) begin
        at = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL frame_start_timeout: observed no pulse within %0d Clk, expected one", budget);
    end
  endtask

  // Returns one Clk after the frame_start edge, so ball updates are visible.
  task automatic next_frame();
    int unsigned at;
    bit ok;
    wait_frame_start(FRAME_CLK + 8, at, ok);
    @(negedge Clk);
  endtask

  task automatic check_ball(input string tag, input int x0, input int x1, input int y0, input int y1);
    expect_val(x0); expect_val(x1); expect_val(y0); expect_val(y1);
    check({tag, "_x0"}, {22'b0, dut.ball_x[0]});
    check({tag, "_x1"}, {22'b0, dut.ball_x[1]});
    check({tag, "_y0"}, {22'b0, dut.ball_y[0]});
    check({tag, "_y1"}, {22'b0, dut.ball_y[1]});
  endtask

  task automatic check_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [23:0] rgb, input logic exp_blank);
    bit found;
    logic [31:0] dummy;
    found = 1'b0;
    expect_val({8'h00, rgb});
    expect_val({31'b0, exp_blank});
    for (int n = 0; n < FRAME_CLK + 8; n++) begin
      @(negedge Clk);
      if (DrawX == x && DrawY == y) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $error("FAIL %s: observed pixel never reached, expected (%0d,%0d)", tag, x, y);
      dummy = exp_q.pop_front();
      dummy = exp_q.pop_front();
      return;
    end
    // Outputs for pixel x appear at the pe edge that moves DrawX to x+1.
    repeat (2) @(negedge Clk);
    check({tag, "_rgb"}, {8'h00, Red, Green, Blue});
    check({tag, "_blank"}, {31'b0, blank});
  endtask

  task automatic check_reset_state(input string tag);
    expect_val(1); expect_val(1); expect_val(0); expect_val(0); expect_val(0);
    expect_val(0); expect_val(0); expect_val(0); expect_val(0); expect_val(0);
    expect_val(0); expect_val(0);
    check({tag, "_hs"}, {31'b0, hs});
    check({tag, "_vs"}, {31'b0, vs});
    check({tag, "_blank"}, {31'b0, blank});
    check({tag, "_rgb"}, {8'h00, Red, Green, Blue});
    check({tag, "_frame_start"}, {31'b0, frame_start});
    check({tag, "_drawx"}, {22'b0, DrawX});
    check({tag, "_drawy"}, {22'b0, DrawY});
    check({tag, "_vga_clk"}, {31'b0, VGA_clk});
    check({tag, "_sync"}, {31'b0, sync});
    check({tag, "_sel"}, {30'b0, dut.sel});
    check({tag, "_xm0"}, {22'b0, dut.ball_xm[0]});
    check({tag, "_ym1"}, {22'b0, dut.ball_ym[1]});
    check_ball(tag, X0_INIT, X1_INIT, Y_INIT, Y_INIT);
  endtask

  task automatic release_and_time(input string tag);
    int unsigned c_rel, at;
    bit ok;
    @(negedge Clk);
    c_rel = cyc;
    Reset = 1'b1;
    expect_val(2 * V_VIS * H_TOT - 2);
    wait_frame_start(2 * FRAME_CLK, at, ok);
    if (ok) check(tag, at - (c_rel + 1));
    else    void'(exp_q.pop_front());
  endtask

  initial begin
    int unsigned c1, c2;
    int hs_lo, vs_lo, blank_hi;
    bit got;

    // Power-on reset and first frame latency.
    repeat (3) @(negedge Clk);
    check_reset_state("init");
    release_and_time("first_fs_latency");
    c1 = cyc;

    // One full frame: period and sync/blank occupancy.
    hs_lo = 0; vs_lo = 0; blank_hi = 0; got = 1'b0; c2 = 0;
    for (int n = 0; n < FRAME_CLK + 8; n++) begin
      @(negedge Clk);
      if (!hs)  hs_lo++;
      if (!vs)  vs_lo++;
      if (blank) blank_hi++;
      if (frame_start) begin
        c2 = cyc;
        got = 1'b1;
        break;
      end
    end
    expect_val(FRAME_CLK);
    expect_val(2 * H_SYNC * V_TOT);
    expect_val(2 * V_SYNC * H_TOT);
    expect_val(2 * H_VIS * V_VIS);
    expect_val(1);
    check("frame_period", c2 - c1);
    check("hs_low_clks", hs_lo);
    check("vs_low_clks", vs_lo);
    check("blank_high_clks", blank_hi);
    check("frame_seen", {31'b0, got});
    @(negedge Clk);

    // Hold D: ball 0 moves right one pixel per frame, ball 1 stays.
    ex_x0 = X0_INIT; ex_x1 = X1_INIT; ex_y0 = Y_INIT; ex_y1 = Y_INIT;
    keycode = 8'h07;
    for (int k = 1; k <= 4; k++) begin
      ex_x0++;
      expect_val(ex_x0);
      next_frame();
      check("x0_right", {22'b0, dut.ball_x[0]});
    end
    check_ball("hold_d", ex_x0, ex_x1, ex_y0, ex_y1);
    while (ex_x0 < X0_EDGE) begin
      ex_x0++;
      expect_val(ex_x0);
      next_frame();
      check("x0_to_edge", {22'b0, dut.ball_x[0]});
    end

    // At the right wall the bounce overrides the held D.
    ex_x0--;
    expect_val(32'h3FF);
    expect_val(ex_x0);
    next_frame();
    check("xm0_bounce", {22'b0, dut.ball_xm[0]});
    check("x0_bounce", {22'b0, dut.ball_x[0]});
    keycode = 8'h00;
    for (int k = 0; k < 4; k++) begin
      ex_x0--;
      expect_val(ex_x0);
      next_frame();
      check("x0_left", {22'b0, dut.ball_x[0]});
    end
    expect_val(32'h3FF);
    check("xm0_still_left", {22'b0, dut.ball_xm[0]});

    // Balls coincide: ball 0 (selected) wins, then blank and background.
    check_ball("overlap", ex_x0, ex_x1, ex_y0, ex_y1);
    check_pixel("overlap_centre", 10'(ex_x0), 10'(ex_y0), 24'hFFFFFF, 1'b1);
    check_pixel("hblank_pixel", 10'(H_VIS + 2), 10'(ex_y0), 24'h000000, 1'b0);
    check_pixel("background", 10'd2, 10'(V_VIS - 2), 24'h000040, 1'b1);

    for (int k = 0; k < 2; k++) begin
      ex_x0--;
      expect_val(ex_x0);
      next_frame();
      check("x0_separate", {22'b0, dut.ball_x[0]});
    end
    check_pixel("sel_ball0", 10'(ex_x0), 10'(ex_y0), 24'hFFFFFF, 1'b1);
    check_pixel("unsel_ball1", 10'(X1_INIT + BALL_SIZE), 10'(ex_y1), 24'hFF5500, 1'b1);

    // Select ball 1, then W moves it up while ball 0 keeps drifting left.
    keycode = 8'h1F;
    ex_x0--;
    expect_val(1);
    expect_val(ex_x0);
    next_frame();
    check("sel_after_1f", {30'b0, dut.sel});
    check("x0_during_sel", {22'b0, dut.ball_x[0]});
    keycode = 8'h1A;
    for (int k = 0; k < 2; k++) begin
      ex_y1--;
      ex_x0--;
      expect_val(ex_y1);
      expect_val(ex_x0);
      next_frame();
      check("y1_up", {22'b0, dut.ball_y[1]});
      check("x0_unaffected", {22'b0, dut.ball_x[0]});
    end
    expect_val(32'h3FF);
    expect_val(0);
    check("ym1_up", {22'b0, dut.ball_ym[1]});
    check("xm1_zero", {22'b0, dut.ball_xm[1]});
    check_ball("after_w", ex_x0, ex_x1, ex_y0, ex_y1);
    check_pixel("sel_ball1", 10'(ex_x1), 10'(ex_y1), 24'hFFFFFF, 1'b1);
    check_pixel("unsel_ball0", 10'(ex_x0), 10'(ex_y0), 24'hFF5500, 1'b1);

    // Key '4' is out of range with two balls.
    keycode = 8'h21;
    ex_y1--;
    ex_x0--;
    expect_val(1);
    next_frame();
    check("sel_ignore_21", {30'b0, dut.sel});
    check_ball("after_21", ex_x0, ex_x1, ex_y0, ex_y1);

    // Mid-frame reset restores everything at once; timing restarts from the origin.
    keycode = 8'h00;
    got = 1'b0;
    for (int n = 0; n < FRAME_CLK + 8; n++) begin
      @(negedge Clk);
      if (DrawY == 10'd12) begin
        got = 1'b1;
        break;
      end
    end
    expect_val(1);
    check("reach_vc12", {31'b0, got});
    Reset = 1'b0;
    #1;
    check_reset_state("midreset");
    repeat (3) @(negedge Clk);
    release_and_time("midreset_fs_latency");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
